// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4:1 mux channel scanner.
// Contents: scan_state_t FSM encoding, NCH (mux data inputs), SEL_W (select width).
package mux_scan_pkg;

    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Next-enabled-channel search for the scanner.
// Ports:
//   en         : channel enable mask
//   sel        : currently selected channel
//   first      : ignore sel and return the lowest enabled channel
//   nxt_c      : next enabled channel index (combinational)
//   has_next_c : a qualifying enabled channel exists (combinational)
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]   en,
    input  logic [SEL_W-1:0] sel,
    input  logic             first,
    output logic [SEL_W-1:0] nxt_c,
    output logic             has_next_c
);

    // Lowest enabled index strictly above sel (or lowest overall when first).
    always_comb begin
        nxt_c      = '0;
        has_next_c = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!has_next_c && en[i] && (first || (i > 32'(sel)))) begin
                nxt_c      = SEL_W'(i);
                has_next_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Time-division scanner for the 4:1 select mux: steps s1:s0 over the enabled
// channels, holds each for DWELL cycles, captures y at the end of each dwell
// and publishes a per-frame snapshot.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start, stop  : begin a frame (IDLE only) / abort a frame (DWELL)
//   chan_en      : channel enable mask, latched at start
//   y            : mux output
//   s0, s1       : registered mux select
//   sample       : last completed frame snapshot
//   frame_valid  : one-cycle pulse when sample updates
//   busy         : frame in progress
//   start_err    : one-cycle pulse on start with an empty mask
// Configuration: define MUX_SCAN_CONT_EN for back-to-back continuous frames.
module mux_scan_ctrl
    import mux_scan_pkg::NCH, mux_scan_pkg::SEL_W, mux_scan_pkg::scan_state_t;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic [NCH-1:0] chan_en,
    input  logic           y,
    output logic           s0,
    output logic           s1,
    output logic [NCH-1:0] sample,
    output logic           frame_valid,
    output logic           busy,
    output logic           start_err
);

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

`ifdef MUX_SCAN_CONT_EN
    localparam logic CONT = 1'b1;
`else
    localparam logic CONT = 1'b0;
`endif

    scan_state_t      state_q, state_d;
    logic [NCH-1:0]   en_q, en_d;
    logic [NCH-1:0]   shadow_q, shadow_d, shadow_cap;
    logic [NCH-1:0]   sample_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_valid_d, busy_d, start_err_d;

    logic [NCH-1:0]   search_en_c;
    logic             search_first_c;
    logic [SEL_W-1:0] nxt_c;
    logic             has_next_c;

    // In IDLE search the incoming mask; DONE re-arm restarts from the bottom.
    assign search_en_c    = (state_q == mux_scan_pkg::IDLE) ? chan_en : en_q;
    assign search_first_c = (state_q != mux_scan_pkg::DWELL);

    mux_scan_next_ch u_next_ch (
        .en         (search_en_c),
        .sel        (sel_q),
        .first      (search_first_c),
        .nxt_c      (nxt_c),
        .has_next_c (has_next_c)
    );

    assign s0 = sel_q[0];
    assign s1 = sel_q[1];

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        en_d          = en_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        sample_d      = sample;
        frame_valid_d = 1'b0;
        busy_d        = busy;
        start_err_d   = 1'b0;

        shadow_cap        = shadow_q;
        shadow_cap[sel_q] = y;

        case (state_q)
            mux_scan_pkg::IDLE: begin
                if (start) begin
                    if (|chan_en) begin
                        en_d     = chan_en;
                        shadow_d = '0;
                        sel_d    = nxt_c;
                        cnt_d    = DWELL_M1;
                        busy_d   = 1'b1;
                        state_d  = mux_scan_pkg::DWELL;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end

            mux_scan_pkg::DWELL: begin
                // Abort wins over a capture on the same edge.
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = mux_scan_pkg::IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shadow_d = shadow_cap;
                    if (has_next_c) begin
                        sel_d = nxt_c;
                        cnt_d = DWELL_M1;
                    end else begin
                        sample_d      = shadow_cap;
                        frame_valid_d = 1'b1;
                        busy_d        = CONT;
                        state_d       = mux_scan_pkg::DONE;
                    end
                end
            end

            mux_scan_pkg::DONE: begin
`ifdef MUX_SCAN_CONT_EN
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = mux_scan_pkg::IDLE;
                end else begin
                    shadow_d = '0;
                    sel_d    = nxt_c;
                    cnt_d    = DWELL_M1;
                    busy_d   = 1'b1;
                    state_d  = mux_scan_pkg::DWELL;
                end
`else
                state_d = mux_scan_pkg::IDLE;
`endif
            end

            default: begin
                busy_d  = 1'b0;
                state_d = mux_scan_pkg::IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= mux_scan_pkg::IDLE;
            en_q        <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            sample      <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            sample      <= sample_d;
            frame_valid <= frame_valid_d;
            busy        <= busy_d;
            start_err   <= start_err_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl; y comes from a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       stop;
    logic [3:0] chan_en;
    logic [3:0] data;
    logic       start_a, start_b, start_c;

    logic       y_a, s0_a, s1_a, fv_a, busy_a, serr_a;
    logic [3:0] sample_a;
    logic       y_b, s0_b, s1_b, fv_b, busy_b, serr_b;
    logic [3:0] sample_b;
    logic       y_c, s0_c, s1_c, fv_c, busy_c, serr_c;
    logic [3:0] sample_c;

    int total = 0;
    int bad   = 0;

    assign y_a = data[{s1_a, s0_a}];
    assign y_b = data[{s1_b, s0_b}];
    assign y_c = data[{s1_c, s0_c}];

    mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .chan_en(chan_en),
        .y(y_a), .s0(s0_a), .s1(s1_a), .sample(sample_a), .frame_valid(fv_a),
        .busy(busy_a), .start_err(serr_a)
    );

    mux_scan_ctrl #(.DWELL(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .chan_en(chan_en),
        .y(y_b), .s0(s0_b), .s1(s1_b), .sample(sample_b), .frame_valid(fv_b),
        .busy(busy_b), .start_err(serr_b)
    );

    mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .stop(stop), .chan_en(chan_en),
        .y(y_c), .s0(s0_c), .s1(s1_c), .sample(sample_c), .frame_valid(fv_c),
        .busy(busy_c), .start_err(serr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        stop    = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        chan_en = 4'b0000;
        data    = 4'b0000;
        tick();
        tick();

        // Reset state
        chk("rst_sel",    8'({s1_a, s0_a}), 8'd0);
        chk("rst_sample", 8'(sample_a), 8'd0);
        chk("rst_fv",     8'(fv_a), 8'd0);
        chk("rst_busy",   8'(busy_a), 8'd0);
        chk("rst_serr",   8'(serr_a), 8'd0);
        chk("rst_b_busy", 8'(busy_b), 8'd0);
        rst_n = 1'b1;
        tick();

`ifndef MUX_SCAN_CONT_EN
        // Empty mask start
        chan_en = 4'b0000;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("serr_pulse",  8'(serr_a), 8'd1);
        chk("serr_busy",   8'(busy_a), 8'd0);
        chk("serr_sel",    8'({s1_a, s0_a}), 8'd0);
        chk("serr_sample", 8'(sample_a), 8'd0);
        tick();
        chk("serr_clear",  8'(serr_a), 8'd0);
        chk("serr_busy2",  8'(busy_a), 8'd0);

        // Full frame, DWELL=4, all channels
        data    = 4'b1101;
        chan_en = 4'b1111;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("f1_sel0", 8'({s1_a, s0_a}), 8'd0);
        chk("f1_busy", 8'(busy_a), 8'd1);
        chk("f1_fv0",  8'(fv_a), 8'd0);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("f1_sel_step", 8'({s1_a, s0_a}), 8'(k / 4));
            chk("f1_fv_low",   8'(fv_a), 8'd0);
            chk("f1_busy_hi",  8'(busy_a), 8'd1);
        end
        tick();
        chk("f1_fv",      8'(fv_a), 8'd1);
        chk("f1_sample",  8'(sample_a), 8'b1101);
        chk("f1_busy_lo", 8'(busy_a), 8'd0);
        chk("f1_sel_end", 8'({s1_a, s0_a}), 8'd3);
        tick();
        chk("f1_fv_drop",    8'(fv_a), 8'd0);
        chk("f1_sample_hld", 8'(sample_a), 8'b1101);

        // Sparse mask, DWELL=2
        data    = 4'b1111;
        chan_en = 4'b1010;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("f2_sel_e0", 8'({s1_b, s0_b}), 8'd1);
        chk("f2_busy",   8'(busy_b), 8'd1);
        tick();
        chk("f2_sel_e1", 8'({s1_b, s0_b}), 8'd1);
        tick();
        chk("f2_sel_e2", 8'({s1_b, s0_b}), 8'd3);
        tick();
        chk("f2_sel_e3", 8'({s1_b, s0_b}), 8'd3);
        chk("f2_fv_low", 8'(fv_b), 8'd0);
        tick();
        chk("f2_fv",      8'(fv_b), 8'd1);
        chk("f2_sample",  8'(sample_b), 8'b1010);
        chk("f2_busy_lo", 8'(busy_b), 8'd0);
        tick();
        chk("f2_fv_drop", 8'(fv_b), 8'd0);

        // Stop during channel 2 dwell
        data    = 4'b0000;
        chan_en = 4'b1111;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (9) tick();
        chk("stop_pre_sel", 8'({s1_a, s0_a}), 8'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy",   8'(busy_a), 8'd0);
        chk("stop_fv",     8'(fv_a), 8'd0);
        chk("stop_sample", 8'(sample_a), 8'b1101);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("stop_fv_after",   8'(fv_a), 8'd0);
            chk("stop_busy_after", 8'(busy_a), 8'd0);
        end
        chk("stop_sample_hld", 8'(sample_a), 8'b1101);

        // start and chan_en changes mid-frame are ignored
        data    = 4'b0001;
        chan_en = 4'b0101;
        start_a = 1'b1;
        tick();
        chk("ign_sel0", 8'({s1_a, s0_a}), 8'd0);
        chan_en = 4'b1111;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("ign_sel",  8'({s1_a, s0_a}), (k < 4) ? 8'd0 : 8'd2);
            chk("ign_busy", 8'(busy_a), 8'd1);
            chk("ign_fv",   8'(fv_a), 8'd0);
            if (k == 5) start_a = 1'b0;
        end
        tick();
        chk("ign_fv_end",  8'(fv_a), 8'd1);
        chk("ign_sample",  8'(sample_a), 8'b0001);
        chk("ign_busy_lo", 8'(busy_a), 8'd0);
        chk("ign_sel_end", 8'({s1_a, s0_a}), 8'd2);
        tick();
        chk("ign_fv_drop", 8'(fv_a), 8'd0);

        // Reset mid-frame
        chan_en = 4'b1111;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_sel",    8'({s1_a, s0_a}), 8'd0);
        chk("mrst_sample", 8'(sample_a), 8'd0);
        chk("mrst_fv",     8'(fv_a), 8'd0);
        chk("mrst_busy",   8'(busy_a), 8'd0);
        chk("mrst_serr",   8'(serr_a), 8'd0);
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            chk("mrst_fv_after", 8'(fv_a), 8'd0);
        end

        // DWELL=1 single channel single frame
        data    = 4'b0001;
        chan_en = 4'b0001;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        chk("c_sel",  8'({s1_c, s0_c}), 8'd0);
        chk("c_busy", 8'(busy_c), 8'd1);
        chk("c_fv0",  8'(fv_c), 8'd0);
        tick();
        chk("c_fv",      8'(fv_c), 8'd1);
        chk("c_sample",  8'(sample_c), 8'b0001);
        chk("c_busy_lo", 8'(busy_c), 8'd0);
        tick();
        chk("c_fv_drop", 8'(fv_c), 8'd0);
        chk("c_idle",    8'(busy_c), 8'd0);
`else
        // Continuous frames, DWELL=1, single channel
        data    = 4'b0001;
        chan_en = 4'b0001;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        chk("cc_busy0", 8'(busy_c), 8'd1);
        chk("cc_fv0",   8'(fv_c), 8'd0);
        tick();
        chk("cc_fv1",     8'(fv_c), 8'd1);
        chk("cc_busy1",   8'(busy_c), 8'd1);
        chk("cc_sample1", 8'(sample_c), 8'b0001);
        tick();
        chk("cc_fv2",   8'(fv_c), 8'd0);
        chk("cc_busy2", 8'(busy_c), 8'd1);
        tick();
        chk("cc_fv3",   8'(fv_c), 8'd1);
        chk("cc_busy3", 8'(busy_c), 8'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("cc_stop_busy", 8'(busy_c), 8'd0);
        chk("cc_stop_fv",   8'(fv_c), 8'd0);
        tick();
        chk("cc_idle_busy", 8'(busy_c), 8'd0);
        chk("cc_idle_fv",   8'(fv_c), 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
